// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; samples each bit at its centre using a 2-flop synchronized line.
// Good bytes raise a one-clk Flag_Rx; a low stop bit raises frame_err and waits for the line to go idle.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] UART_Rx,
  output logic       Flag_Rx,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]      os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            flag_q, flag_d;
  logic            ferr_q, ferr_d;
  logic            tick;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign UART_Rx   = rx_byte_q;
  assign Flag_Rx   = flag_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    os_cnt_d  = tick ? os_cnt_q + 4'd1 : os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    flag_d    = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Restart both counters so the mid-bit sample lands relative to this edge.
        if (!rx_s_q) begin
          state_d   = ST_START;
          div_cnt_d = '0;
          os_cnt_d  = 4'd0;
        end
      end
      ST_START: begin
        if (tick && os_cnt_q == 4'd7) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            os_cnt_d  = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick && os_cnt_q == 4'd15) begin
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (tick && os_cnt_q == 4'd15) begin
          if (rx_s_q) begin
            rx_byte_d = shift_q;
            flag_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_cnt_q <= '0;
      os_cnt_q  <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_byte_q <= 8'h00;
      flag_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      flag_q    <= flag_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk/bit: a frame-level model predicts each pulse, its byte and its latency window.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] UART_Rx;
  logic       Flag_Rx;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_HZ(1600000), .BAUD(100000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .UART_Rx(UART_Rx), .Flag_Rx(Flag_Rx), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         good;
    logic [7:0] data;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_byte = 8'h00;
  logic [7:0] flag_log[$];
  int         flag_cyc[$];
  int         ferr_cnt = 0;
  bit         idle_expected = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {UART_Rx, Flag_Rx, frame_err, busy}, 32'h0);
      exp_q.delete();
      exp_byte = 8'h00;
    end else begin
      chk("pulse_exclusive", {31'd0, Flag_Rx & frame_err}, 32'd0);
      if (Flag_Rx || frame_err) begin
        if (frame_err) ferr_cnt++;
        if (Flag_Rx) begin
          flag_log.push_back(UART_Rx);
          flag_cyc.push_back(cyc);
        end
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: flag=%0b ferr=%0b at cycle %0d, none required", Flag_Rx, frame_err, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_is_flag", {31'd0, Flag_Rx}, {31'd0, e.good});
          n_cmp++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_bad++;
            $display("FAIL pulse_latency: at cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
          end
          if (e.good) exp_byte = e.data;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
        n_cmp++; n_bad++;
        $display("FAIL missed_pulse: none by cycle %0d, required by %0d", cyc, exp_q[0].hi);
        void'(exp_q.pop_front());
      end
      chk("uart_rx_value", {24'd0, UART_Rx}, {24'd0, exp_byte});
      if (idle_expected) chk("idle_busy", {31'd0, busy}, 32'd0);
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.good = stop_ok;
    e.data = b;
    e.lo   = cyc + 153;
    e.hi   = cyc + 157;
    exp_q.push_back(e);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(b[i], 16);
    drive(stop_ok, 16);
  endtask

  task automatic clear_logs();
    flag_log.delete();
    flag_cyc.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    int t0;
    logic [7:0] b2b[3];
    b2b[0] = 8'hFE; b2b[1] = 8'h02; b2b[2] = 8'h03;

    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Idle line after power-up.
    idle_expected = 1'b1;
    drive(1'b1, 1000);
    idle_expected = 1'b0;
    chk("powerup_no_flag", flag_log.size(), 0);
    chk("powerup_no_ferr", ferr_cnt, 0);

    // Single good byte.
    clear_logs();
    send_byte(8'hFE, 1'b1);
    chk("fe_busy_after", {31'd0, busy}, 32'd0);
    drive(1'b1, 20);
    chk("fe_flag_count", flag_log.size(), 1);
    chk("fe_byte", {24'd0, UART_Rx}, 32'hFE);
    chk("fe_no_ferr", ferr_cnt, 0);

    // Back-to-back frames.
    clear_logs();
    for (int i = 0; i < 3; i++) send_byte(b2b[i], 1'b1);
    drive(1'b1, 20);
    chk("b2b_flag_count", flag_log.size(), 3);
    if (flag_log.size() == 3) begin
      chk("b2b_byte0", {24'd0, flag_log[0]}, 32'hFE);
      chk("b2b_byte1", {24'd0, flag_log[1]}, 32'h02);
      chk("b2b_byte2", {24'd0, flag_log[2]}, 32'h03);
      for (int i = 1; i < 3; i++)
        chk("b2b_spacing_ok", {31'd0, (flag_cyc[i] - flag_cyc[i-1] >= 154) && (flag_cyc[i] - flag_cyc[i-1] <= 162)}, 32'd1);
    end

    // Short glitch is rejected.
    clear_logs();
    t0 = cyc;
    drive(1'b0, 4);
    drive(1'b1, 1);
    chk("glitch_busy_in_start", {31'd0, busy}, 32'd1);
    while (cyc < t0 + 14) drive(1'b1, 1);
    chk("glitch_busy_cleared", {31'd0, busy}, 32'd0);
    drive(1'b1, 40);
    chk("glitch_no_flag", flag_log.size(), 0);
    chk("glitch_no_ferr", ferr_cnt, 0);

    // Framing error followed by a held-low line, then recovery.
    send_byte(8'hA5, 1'b1);
    drive(1'b1, 10);
    clear_logs();
    send_byte(8'h55, 1'b0);
    drive(1'b0, 200);
    chk("ferr_busy_while_low", {31'd0, busy}, 32'd1);
    chk("ferr_byte_held", {24'd0, UART_Rx}, 32'hA5);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_no_flag", flag_log.size(), 0);
    drive(1'b1, 6);
    chk("ferr_busy_after_high", {31'd0, busy}, 32'd0);
    send_byte(8'h3C, 1'b1);
    drive(1'b1, 10);
    chk("recover_byte", {24'd0, UART_Rx}, 32'h3C);

    // Reset during data bit 4 of 0x81.
    clear_logs();
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 48);
    drive(1'b0, 8);
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte", {24'd0, UART_Rx}, 32'h00);
    drive(1'b1, 10);
    rst = 1'b1;
    drive(1'b1, 30);
    chk("rst_no_flag", flag_log.size(), 0);
    chk("rst_idle_after", {31'd0, busy}, 32'd0);
    send_byte(8'h7E, 1'b1);
    drive(1'b1, 10);
    chk("rst_next_flag_count", flag_log.size(), 1);
    chk("rst_next_byte", {24'd0, UART_Rx}, 32'h7E);

    drive(1'b1, 50);
    chk("model_drained", exp_q.size(), 0);
    chk("total_ferr_after_reset_test", ferr_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: serial bit rate.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-006 SHALL have port UART_Rx  output  8  last correctly framed received byte; held until the next good byte.
REQ-007 SHALL have port Flag_Rx  output  1  one-clk pulse; UART_Rx holds a new valid byte in this cycle.
REQ-008 SHALL have port frame_err  output  1  one-clk pulse; the stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s); rx_s SHALL reset to 1; all decisions use rx_s only.
REQ-011 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks (integer floor; forced to 1 if 0); tick is one clk wide.
REQ-012 SHALL clear the tick divider and the 4-bit oversample counter on entry to START, so that sampling is phase-aligned to the detected edge.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rx_s==0 -> START; otherwise stay.
REQ-015 START: on the 8th tick (mid start bit), rx_s==0 -> DATA with bit index 0 and counter cleared; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: on every 16th tick, sample rx_s into shift-register bit [index]; after index 7 is sampled -> STOP.
REQ-017 STOP: on the 16th tick, rx_s==1 -> load UART_Rx from the shift register, pulse Flag_Rx, -> IDLE.
REQ-018 STOP: on the 16th tick, rx_s==0 -> pulse frame_err, leave UART_Rx unchanged, no Flag_Rx, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rx_s==1, then -> IDLE (a held-low break line SHALL not start a new frame).
REQ-020 Flag_Rx and frame_err SHALL be registered, SHALL never both be high, and SHALL be high for exactly one clk per frame.
REQ-021 A start bit that follows the stop bit immediately (back-to-back frames) SHALL be received without loss, since the return to IDLE occurs at mid stop bit.
REQ-022 rx changes during a non-sampling tick SHALL have no effect; only the scheduled mid-bit samples SHALL count.
REQ-023 Illegal state encodings SHALL return to IDLE on the next clk.
REQ-024 With CLK_HZ=1600000 and BAUD=100000 (DIV=1, 16 clk/bit), Flag_Rx SHALL rise 153-157 clks after the rx start-bit falling edge.

Reset
REQ-025 rst==0 SHALL asynchronously force: state IDLE, UART_Rx=8'h00, Flag_Rx=0, frame_err=0, busy=0, rx_s=1, all counters and the shift register 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse. After release, the block SHALL wait in IDLE for the next falling edge.

Verification (CLK_HZ=1600000, BAUD=100000)
REQ-027 Send 0xFE with a good stop bit -> exactly one Flag_Rx pulse, UART_Rx=8'hFE, frame_err stays 0, busy falls after the pulse.
REQ-028 Send 0xFE, 0x02, 0x03 back-to-back with no idle gap -> three Flag_Rx pulses carrying FE, 02, 03 in order; 154-162 clks apart.
REQ-029 Drive rx low for 4 clks, then high -> no Flag_Rx, no frame_err; busy returns to 0 within 12 clks of the start of START.
REQ-030 After good byte 0xA5, send 0x55 with stop bit low and hold rx low 200 clks -> one frame_err pulse, UART_Rx stays 8'hA5, no Flag_Rx, busy high until rx returns high; a following good 0x3C -> UART_Rx=8'h3C.
REQ-031 Assert rst during data bit 4 of 0x81, release, then send 0x7E -> outputs all 0 during reset, no pulse for the aborted frame, one Flag_Rx with UART_Rx=8'h7E.
REQ-032 Power-up with rx high and no traffic for 1000 clks -> Flag_Rx=0, frame_err=0, busy=0, UART_Rx=8'h00 throughout.
